// File: rtl/adxl362_spi_responder_pkg.sv
// Shared constants for the ADXL362 SPI responder: command codes, register
// map, fixed ID values, soft-reset key and FSM state encoding.
package adxl362_spi_responder_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] CMD_FIFO_READ  = 8'h0D;

  localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;
  localparam logic [7:0] REVID_VAL      = 8'h01;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] WR_REG_DEFAULT = 8'h00;

  localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
  localparam logic [5:0] ADDR_PARTID     = 6'h02;
  localparam logic [5:0] ADDR_REVID      = 6'h03;
  localparam logic [5:0] ADDR_XDATA      = 6'h08;
  localparam logic [5:0] ADDR_YDATA      = 6'h09;
  localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
  localparam logic [5:0] ADDR_STATUS     = 6'h0B;
  localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
  localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
  localparam logic [5:0] ADDR_WR_FIRST   = 6'h1F;
  localparam logic [5:0] ADDR_WR_LAST    = 6'h2E;

  localparam int NUM_WR_REGS = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_IGNORE  = 3'd5
  } state_t;

  // High byte of a 12-bit sample: sign-extended upper nibble.
  function automatic logic [7:0] sample_hi(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

  function automatic logic is_writable(input logic [5:0] a);
    return (a >= ADDR_WR_FIRST) && (a <= ADDR_WR_LAST);
  endfunction

  // 0x1F..0x2E maps onto 0..15 by adding one to the low nibble (0xF wraps to 0).
  function automatic logic [3:0] wr_index(input logic [5:0] a);
    return a[3:0] + 4'd1;
  endfunction

endpackage

// File: rtl/adxl362_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer with optional rise/fall detection on the
// synchronized level.
module adxl362_spi_responder_spi_sync_edge
  import adxl362_spi_responder_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0,
  parameter bit   EDGE_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // Remember the previous synchronized level for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RESET_VAL;
        else        prev_q <= dout;
      end

      assign rise = dout & ~prev_q;
      assign fall = ~dout & prev_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-protocol SPI slave (mode 0) for PmodACL2 bench use.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cs_n high (or not yet seen high since reset), waiting for fall
// ST_CMD     | shifting in the command byte
// ST_ADDR    | shifting in the register address byte
// ST_WR_DATA | each completed byte writes addr, then addr increments
// ST_RD_DATA | miso shifts snapshotted bytes out, addr increments per byte
// ST_IGNORE  | unsupported command or post-soft-reset; miso held at 0
module adxl362_spi_responder
  import adxl362_spi_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        sample_valid,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] txn_count
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  adxl362_spi_responder_spi_sync_edge #(
    .STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)
  ) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n restarts low out of reset: a low cs_n at release produces no fall,
  // so a transaction already in flight is skipped until cs_n goes high.
  adxl362_spi_responder_spi_sync_edge #(
    .STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)
  ) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .dout(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  adxl362_spi_responder_spi_sync_edge #(
    .STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)
  ) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_in_q;
  logic [7:0]  shift_out_q;
  logic [5:0]  addr_q;
  logic        is_wr_q;
  logic        byte_seen_q;
  logic        status_q;
  logic [11:0] sx_q, sy_q, sz_q;
  logic [7:0]  regs_q [NUM_WR_REGS];

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        wr_hit;
  logic        soft_reset_hit;
  logic        rd_load;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  assign rx_byte        = {shift_in_q, mosi_s};
  assign byte_done      = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
  assign wr_hit         = (state_q == ST_WR_DATA) && byte_done && is_writable(addr_q);
  assign soft_reset_hit = wr_hit && (addr_q == ADDR_SOFT_RESET) && (rx_byte == SOFT_RESET_KEY);
  assign rd_load        = byte_done &&
                          (((state_q == ST_ADDR) && !is_wr_q) || (state_q == ST_RD_DATA));
  assign rd_addr        = (state_q == ST_ADDR) ? rx_byte[5:0] : addr_q + 6'd1;

  // Register read mux, evaluated at the address about to be loaded.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST_VAL;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_REVID:     rd_data = REVID_VAL;
      ADDR_XDATA:     rd_data = sx_q[11:4];
      ADDR_YDATA:     rd_data = sy_q[11:4];
      ADDR_ZDATA:     rd_data = sz_q[11:4];
      ADDR_STATUS:    rd_data = {7'b0, status_q};
      ADDR_XDATA_L:   rd_data = sx_q[7:0];
      ADDR_XDATA_H:   rd_data = sample_hi(sx_q);
      ADDR_YDATA_L:   rd_data = sy_q[7:0];
      ADDR_YDATA_H:   rd_data = sample_hi(sy_q);
      ADDR_ZDATA_L:   rd_data = sz_q[7:0];
      ADDR_ZDATA_H:   rd_data = sample_hi(sz_q);
      default: begin
        if (is_writable(rd_addr)) rd_data = regs_q[wr_index(rd_addr)];
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; cs_n rise aborts from any state.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (byte_done) begin
            if ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ)) state_d = ST_ADDR;
            else                                                  state_d = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (byte_done) state_d = is_wr_q ? ST_WR_DATA : ST_RD_DATA;
        end
        ST_WR_DATA: begin
          if (soft_reset_hit) state_d = ST_IGNORE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Sample capture and DATA_READY; a new sample beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q     <= '0;
      sy_q     <= '0;
      sz_q     <= '0;
      status_q <= 1'b0;
    end else begin
      if (sample_valid) begin
        sx_q <= sample_x;
        sy_q <= sample_y;
        sz_q <= sample_z;
      end
      if (sample_valid)
        status_q <= 1'b1;
      else if (soft_reset_hit || (rd_load && (rd_addr == ADDR_XDATA_L)))
        status_q <= 1'b0;
    end
  end

  // Bit/byte shifting, address tracking, miso drive and transaction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      byte_seen_q <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      txn_count   <= '0;
    end else if (cs_rise) begin
      bit_cnt_q   <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      byte_seen_q <= 1'b0;
      if (byte_seen_q) txn_count <= txn_count + 16'd1;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        bit_cnt_q   <= '0;
        byte_seen_q <= 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        shift_in_q <= rx_byte[6:0];
        bit_cnt_q  <= bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        byte_seen_q <= 1'b1;
        case (state_q)
          ST_CMD:                 is_wr_q <= (rx_byte == CMD_WRITE);
          ST_ADDR:                addr_q  <= rx_byte[5:0];
          ST_WR_DATA, ST_RD_DATA: addr_q  <= addr_q + 6'd1;
          default: ;
        endcase
      end
      if (rd_load) begin
        shift_out_q <= rd_data;
      end else if (sclk_fall && (state_q == ST_RD_DATA)) begin
        miso        <= shift_out_q[7];
        miso_oe     <= 1'b1;
        shift_out_q <= {shift_out_q[6:0], 1'b0};
      end
    end
  end

  // Writable register file and the write report; soft reset overrides the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NUM_WR_REGS; i++) regs_q[i] <= WR_REG_DEFAULT;
    end else begin
      wr_strobe <= 1'b0;
      if (wr_hit && !cs_rise) begin
        wr_strobe               <= 1'b1;
        wr_addr                 <= addr_q;
        wr_data                 <= rx_byte;
        regs_q[wr_index(addr_q)] <= rx_byte;
      end
      if (soft_reset_hit && !cs_rise) begin
        for (int i = 0; i < NUM_WR_REGS; i++) regs_q[i] <= WR_REG_DEFAULT;
      end
    end
  end

endmodule
